// File: rtl/soc_system_pio_pkg.sv
// soc_system_pio_pkg: register addresses and edge-select encodings for the input PIO
package soc_system_pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY = 2;
endpackage

// File: rtl/soc_system_pio_debounce.sv
// soc_system_pio_debounce: two-flop synchronizer plus stability counter for one input bit
module soc_system_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
      q <= IDLE_LEVEL;
      cnt <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      // any sample matching the accepted level restarts the stability window
      if (sync2 == q) cnt <= '0;
      else if (cnt == LAST) begin
        q <= sync2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/soc_system_pio_key_in.sv
// soc_system_pio_key_in: debounced key/switch input PIO with mask, edge capture and level irq
module soc_system_pio_key_in
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter int EDGE_TYPE = EDGE_FALL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] stable, stable_d, irq_mask, edge_cap, edge_det, clr;
  logic [31:0] rd_mux;
  logic wr;
  logic unused_wd;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL(IDLE_LEVEL)
    ) u_db (
      .clk(clk),
      .reset(reset),
      .d(in_port[i]),
      .q(stable[i])
    );
  end
  always_comb begin
    wr = chipselect & ~write_n;
    edge_det = EDGE_TYPE == EDGE_RISE ? stable & ~stable_d :
               EDGE_TYPE == EDGE_FALL ? ~stable & stable_d : stable ^ stable_d;
    clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    rd_mux = address == ADDR_DATA    ? 32'(stable) :
             address == ADDR_IRQMASK ? 32'(irq_mask) :
             address == ADDR_EDGECAP ? 32'(edge_cap) : 32'd0;
    unused_wd = ^writedata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= {WIDTH{IDLE_LEVEL}};
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      stable_d <= stable;
      // a fresh edge outranks a simultaneous write-1-to-clear
      edge_cap <= (edge_cap & ~clr) | edge_det;
      if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      readdata <= rd_mux;
    end
  end
  assign irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_soc_system_pio_key_in.sv
// tb_soc_system_pio_key_in: directed stimulus against a sample-window model of the key PIO
module tb_soc_system_pio_key_in;
  localparam int W = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [W-1:0] in_port = 4'hF;
  logic [31:0] readdata;
  logic irq;
  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_stable, m_stable_d, m_mask, m_cap, m_fall, m_clr;
  logic [31:0] m_rd;
  bit same;
  logic [31:0] v;

  soc_system_pio_key_in #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .IDLE_LEVEL(1'b1),
    .EDGE_TYPE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // hist[i] holds the input sampled i+1 edges ago; a bit is accepted once the
  // D samples taken two or more edges back all agree on a new level
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= D; i++) hist[i] = {W{1'b1}};
      m_stable = {W{1'b1}};
      m_stable_d = {W{1'b1}};
      m_mask = '0;
      m_cap = '0;
      m_rd = '0;
    end else begin
      m_rd = address == 2'd0 ? {28'd0, m_stable} :
             address == 2'd2 ? {28'd0, m_mask} :
             address == 2'd3 ? {28'd0, m_cap} : 32'd0;
      m_fall = ~m_stable & m_stable_d;
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~m_clr) | m_fall;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_stable_d = m_stable;
      for (int b = 0; b < W; b++) begin
        same = 1'b1;
        for (int i = 2; i <= D; i++) if (hist[i][b] != hist[1][b]) same = 1'b0;
        if (same && hist[1][b] != m_stable[b]) m_stable[b] = hist[1][b];
      end
      for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = in_port;
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("readdata", readdata, m_rd);
      check("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(2'd0, v); check("reset_data", v, 32'h0000000F);
    rd(2'd3, v); check("reset_edgecap", v, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    // bit0 falls: accepted at k+5, visible through registered read at k+6
    address = 2'd0;
    in_port = 4'hE;
    repeat (6) @(negedge clk);
    check("data_k5", readdata, 32'h0000000F);
    @(negedge clk);
    check("data_k6", readdata, 32'h0000000E);
    rd(2'd3, v); check("cap_bit0", v, 32'h1);
    check("irq_masked", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h1);
    check("irq_unmask", {31'd0, irq}, 32'h1);
    // two 3-cycle glitches on bit1 separated by one high sample
    in_port = 4'hC;
    repeat (3) @(negedge clk);
    in_port = 4'hE;
    @(negedge clk);
    in_port = 4'hC;
    repeat (3) @(negedge clk);
    in_port = 4'hE;
    repeat (10) @(negedge clk);
    rd(2'd0, v); check("glitch_data", v, 32'h0000000E);
    rd(2'd3, v); check("glitch_cap", v, 32'h1);
    // capture bit1 then clear bit0
    in_port = 4'hC;
    repeat (10) @(negedge clk);
    rd(2'd3, v); check("cap_3", v, 32'h3);
    wr(2'd3, 32'h1);
    rd(2'd3, v); check("clear_bit0", v, 32'h2);
    in_port = 4'hE;
    repeat (10) @(negedge clk);
    rd(2'd3, v); check("rise_ignored", v, 32'h2);
    // clear of bit1 lands on the same edge its new fall is captured
    in_port = 4'hC;
    repeat (6) @(negedge clk);
    wr(2'd3, 32'h2);
    rd(2'd3, v); check("set_wins", v, 32'h2);
    rd(2'd1, v); check("rsvd", v, 32'h0);
    wr(2'd2, 32'hFFFFFFFF);
    rd(2'd2, v); check("mask_width", v, 32'h0000000F);
    wr(2'd0, 32'h0);
    rd(2'd0, v); check("data_ro", v, 32'h0000000C);
    check("irq_all_mask", {31'd0, irq}, 32'h1);
    // reset while bit2 has counted two cycles toward a fall
    in_port = 4'hF;
    repeat (10) @(negedge clk);
    wr(2'd3, 32'hF);
    rd(2'd3, v); check("cap_cleared", v, 32'h0);
    in_port = 4'hB;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(2'd0, v); check("rst_mid_data", v, 32'h0000000F);
    rd(2'd2, v); check("rst_mid_mask", v, 32'h0);
    rd(2'd3, v); check("rst_mid_cap", v, 32'h0);
    address = 2'd0;
    repeat (10) @(negedge clk);
    rd(2'd0, v); check("post_rst_data", v, 32'h0000000B);
    rd(2'd3, v); check("post_rst_cap", v, 32'h4);
    check("post_rst_irq", {31'd0, irq}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
